hs_mul_seq: RTL and testbench
=============================

// Module: hs_mul_seq
// PURPOSE
//  Parametrised sequential multiplier: two operands shifted in serially (one bit per pin per clk), multiplied
//  iteratively STEP bits per cycle, signed or unsigned, with busy/done handshake.
//  Result is read back OUT_W bits at a time through a slice-select mux.
//  Successor to the latch-based single-cycle 16x16 multiplier: fixed width becomes WIDTH, and the latches are
//  replaced by flops. Adds a selectable step size, a signed mode and a handshake. Sits behind the tile IO pins.
// PARAMETERS
//  WIDTH  16  operand width in bits; product is 2*WIDTH; must be a multiple of STEP and of OUT_W
//  STEP   1   multiplier bits retired per cycle (1, 2, 4 or 8); WIDTH % STEP == 0
//  OUT_W  8   width of readback slice; 2*WIDTH % OUT_W == 0
// PORTS
//  clk          in   1                   clock, all state updates on posedge
//  rst_n        in   1                   synchronous active-low reset
//  sin_a        in   1                   serial operand A bit, MSB first
//  sin_b        in   1                   serial operand B bit, MSB first
//  shift_en     in   1                   shift sin_a/sin_b into shift regs this cycle
//  start        in   1                   begin multiply of current shift-reg contents
//  signed_mode  in   1                   1 = two's-complement operands, 0 = unsigned; sampled at start
//  slice_sel    in   $clog2(2*WIDTH/OUT_W)  selects result[slice_sel*OUT_W +: OUT_W]
//  busy         out  1                   high while a multiply is in progress
//  done         out  1                   one-cycle pulse when result updated
//  dout         out  OUT_W               selected result slice (combinational from result reg + slice_sel)
// BEHAVIOUR
//  Reset (rst_n low at posedge): sr_a, sr_b, operands, acc and result are cleared to 0; busy=0, done=0, state=IDLE.
//    dout is therefore 0 after reset.
//  Shift: in IDLE, shift_en=1 -> sr_a <= {sr_a[WIDTH-2:0],sin_a}, same for sr_b.
//    shift_en is ignored while busy; shift regs hold.
//  Start, when state=IDLE and start=1:
//    - capture magnitudes of sr_a/sr_b into op regs. Signed operands are negated if MSB=1;
//      -2^(WIDTH-1) magnitude 2^(WIDTH-1) fits in WIDTH bits.
//    - record neg = signed_mode & (a_msb ^ b_msb); acc=0; state=RUN; busy=1 on the next cycle.
//  Start and shift_en in the same IDLE cycle: start captures the PRE-shift contents; the shift still occurs.
//  start while busy: ignored, no queuing.
//  RUN: each cycle acc <= acc + (op_a * op_b[STEP-1:0]) << (k*STEP) for iteration k.
//    Equivalently, op_b shifts right by STEP. Runs exactly WIDTH/STEP cycles, then state=FIX.
//  FIX: one cycle. result <= neg ? -acc : acc (2*WIDTH bits, mod 2^(2*WIDTH)); done=1 that cycle.
//    Then busy=0 and state=IDLE.
//  Latency: start sampled at edge 0 -> done high and result valid after edge WIDTH/STEP+1.
//    A new start is accepted on the cycle done is high.
//  result holds its value until the next FIX; dout is readable while busy (old result).
//  Reset mid-operation: the operation is abandoned, all state is cleared, and no done pulse is issued.
//  Widths: acc/result are 2*WIDTH unsigned bits; no overflow possible.
//    Signed -2^(W-1) * -2^(W-1) = 2^(2W-2) is representable.
//  slice_sel out of range (non-power-of-two slice count): dout = 0.
//  FSM: IDLE -(start)-> RUN -(k==WIDTH/STEP-1)-> FIX -> IDLE.
// STRUCTURE
//  Package hs_mul_pkg:
//    - state enum {IDLE, RUN, FIX}
//    - function latency(WIDTH,STEP) = WIDTH/STEP+1
//    - function abs_w for magnitude capture
//  Sub-module hs_mul_step: combinational acc + (op_a * b_chunk) << shift, STEP-bit chunk, 2*WIDTH output.
//  Top holds the shift regs, FSM, iteration counter ($clog2(WIDTH/STEP) bits) and the result/readback mux.
// TESTING
//  1) W=16,S=1: shift in A=3,B=5 (16 clks), unsigned start
//     -> busy for 17 cycles, done pulse once, result=0x0000000F; slice0=0x0F, slice1..3=0x00.
//  2) Unsigned 0xFFFF*0xFFFF -> result 0xFFFE0001.
//     Signed mode same operands -> 0x00000001.
//  3) Signed 0xFFFF*0x0002 -> 0xFFFFFFFE. Signed 0x8000*0x8000 -> 0x40000000. Signed 0x8000*0x0001 -> 0xFFFF8000.
//  4) start pulsed again 5 cycles into RUN, and shift_en toggled while busy
//     -> ignored; result matches the first operands; sr unchanged.
//  5) rst_n low for one cycle mid-RUN -> next cycle busy=0, dout=0, no done; a fresh multiply then completes normally.
//  6) Rebuild with S=4: 0x1234*0x5678 -> 0x06260060 with done exactly 5 cycles after start;
//     random 1000-vector self-check vs reference model, both modes.

Source files
------------

// File: rtl/hs_mul_pkg.sv
// hs_mul_pkg: shared types and helpers for the sequential multiplier.
//   state_t  - controller states (IDLE, RUN, FIX)
//   latency  - cycles from an accepted start to the done pulse
//   abs_w    - magnitude of a w-bit operand, optionally read as two's complement
package hs_mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    function automatic int latency(input int width, input int step);
        return width / step + 1;
    endfunction

    // Operands up to 64 bits wide. The most negative value maps to
    // 2^(w-1), which still fits in w unsigned bits.
    function automatic logic [63:0] abs_w(input logic [63:0] v, input int w, input logic sgn);
        logic [63:0] mask;
        mask = {64{1'b1}} >> (64 - w);
        if (sgn && v[6'(w - 1)])
            return (~v + 64'd1) & mask;
        return v & mask;
    endfunction

endpackage

// File: rtl/hs_mul_step.sv
// hs_mul_step: one combinational iteration of the shift-add multiplier.
//   acc_in   - running 2*WIDTH-bit accumulator
//   op_a     - multiplicand magnitude
//   b_chunk  - next STEP bits of the multiplier
//   shift    - bit position of this chunk (iteration * STEP)
//   acc_out  - acc_in + (op_a * b_chunk) << shift
module hs_mul_step #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int SH_W  = 5
) (
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [STEP-1:0]    b_chunk,
    input  logic [SH_W-1:0]    shift,
    output logic [2*WIDTH-1:0] acc_out
);

    logic [2*WIDTH-1:0] part;

    assign part    = (2*WIDTH)'(op_a) * (2*WIDTH)'(b_chunk);
    assign acc_out = acc_in + (part << shift);

endmodule

// File: rtl/hs_mul_seq.sv
// hs_mul_seq: serial-load, iterative signed/unsigned multiplier.
//   clk, rst_n        - clock, synchronous active-low reset
//   sin_a, sin_b      - serial operand bits, MSB first, loaded while shift_en in IDLE
//   start             - multiply current shift-register contents (IDLE only)
//   signed_mode       - two's-complement operands when 1, sampled with start
//   slice_sel         - selects OUT_W-bit slice of the result for dout
//   busy, done        - in-progress flag and one-cycle completion pulse
//   dout              - result[slice_sel*OUT_W +: OUT_W], 0 for out-of-range selects
// WIDTH is limited to 64 by the magnitude helper.
module hs_mul_seq
    import hs_mul_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int OUT_W = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              sin_a,
    input  logic                              sin_b,
    input  logic                              shift_en,
    input  logic                              start,
    input  logic                              signed_mode,
    input  logic [$clog2(2*WIDTH/OUT_W)-1:0]  slice_sel,
    output logic                              busy,
    output logic                              done,
    output logic [OUT_W-1:0]                  dout
);

    localparam int          ITERS = latency(WIDTH, STEP) - 1;
    localparam int          CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam int          SH_W  = $clog2(2*WIDTH);
    localparam int unsigned NSL   = 2*WIDTH/OUT_W;
    localparam int          SEL_W = $clog2(2*WIDTH/OUT_W);

    state_t             state;
    logic [WIDTH-1:0]   sr_a, sr_b;
    logic [WIDTH-1:0]   op_a, op_b;
    logic [2*WIDTH-1:0] acc, acc_next, result;
    logic [CNT_W-1:0]   iter;
    logic               neg;
    logic [SH_W-1:0]    shift;

    assign shift = SH_W'(iter) * SH_W'(STEP);

    hs_mul_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .SH_W  (SH_W)
    ) u_step (
        .acc_in  (acc),
        .op_a    (op_a),
        .b_chunk (op_b[STEP-1:0]),
        .shift   (shift),
        .acc_out (acc_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            sr_a   <= '0;
            sr_b   <= '0;
            op_a   <= '0;
            op_b   <= '0;
            acc    <= '0;
            result <= '0;
            iter   <= '0;
            neg    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // start captures the pre-shift contents; a simultaneous shift still lands
                    if (start) begin
                        op_a  <= WIDTH'(abs_w(64'(sr_a), WIDTH, signed_mode));
                        op_b  <= WIDTH'(abs_w(64'(sr_b), WIDTH, signed_mode));
                        neg   <= signed_mode & (sr_a[WIDTH-1] ^ sr_b[WIDTH-1]);
                        acc   <= '0;
                        iter  <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                    if (shift_en) begin
                        sr_a <= {sr_a[WIDTH-2:0], sin_a};
                        sr_b <= {sr_b[WIDTH-2:0], sin_b};
                    end
                end
                RUN: begin
                    acc  <= acc_next;
                    op_b <= op_b >> STEP;
                    iter <= iter + 1'b1;
                    if (iter == CNT_W'(ITERS - 1))
                        state <= FIX;
                end
                FIX: begin
                    result <= neg ? -acc : acc;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        dout = '0;
        for (int unsigned i = 0; i < NSL; i++) begin
            if (slice_sel == SEL_W'(i))
                dout = result[i*OUT_W +: OUT_W];
        end
    end

endmodule

// File: tb/tb_hs_mul_seq.sv
module tb_hs_mul_seq;

    logic       clk = 1'b0;
    logic       rst_n, sin_a, sin_b, shift_en, start, signed_mode;
    logic [1:0] slice_sel;
    logic       busy [2];
    logic       done [2];
    logic [7:0] dout [2];

    int   total = 0;
    int   bad   = 0;
    logic chk_on = 1'b0;
    logic rand_sel = 1'b1;

    always #5 clk = ~clk;

    hs_mul_seq #(.WIDTH(16), .STEP(1), .OUT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .sin_a(sin_a), .sin_b(sin_b), .shift_en(shift_en),
        .start(start), .signed_mode(signed_mode), .slice_sel(slice_sel),
        .busy(busy[0]), .done(done[0]), .dout(dout[0])
    );

    hs_mul_seq #(.WIDTH(16), .STEP(4), .OUT_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .sin_a(sin_a), .sin_b(sin_b), .shift_en(shift_en),
        .start(start), .signed_mode(signed_mode), .slice_sel(slice_sel),
        .busy(busy[1]), .done(done[1]), .dout(dout[1])
    );

    // Reference product, straight 64-bit arithmetic.
    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input logic sm);
        longint x, y, p;
        x = sm ? {{48{a[15]}}, a} : {48'b0, a};
        y = sm ? {{48{b[15]}}, b} : {48'b0, b};
        p = x * y;
        return p[31:0];
    endfunction

    // Transaction-level model: shift registers, a countdown to done, and the held result.
    int          lat [2] = '{17, 5};
    logic [15:0] m_sa [2];
    logic [15:0] m_sb [2];
    logic [31:0] m_res [2];
    logic [31:0] m_pend [2];
    int          m_cnt [2];
    logic        m_done [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_sa[i] = '0; m_sb[i] = '0; m_res[i] = '0; m_pend[i] = '0;
                m_cnt[i] = 0; m_done[i] = 1'b0;
            end else begin
                m_done[i] = 1'b0;
                if (m_cnt[i] == 0) begin
                    if (start) begin
                        m_pend[i] = ref_mul(m_sa[i], m_sb[i], signed_mode);
                        m_cnt[i]  = lat[i];
                    end
                    if (shift_en) begin
                        m_sa[i] = {m_sa[i][14:0], sin_a};
                        m_sb[i] = {m_sb[i][14:0], sin_b};
                    end
                end else begin
                    m_cnt[i] = m_cnt[i] - 1;
                    if (m_cnt[i] == 0) begin
                        m_res[i]  = m_pend[i];
                        m_done[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                total++;
                if (busy[i] !== (m_cnt[i] != 0)) begin
                    bad++;
                    $display("FAIL busy[%0d] t=%0t got %b want %b", i, $time, busy[i], (m_cnt[i] != 0));
                end
                total++;
                if (done[i] !== m_done[i]) begin
                    bad++;
                    $display("FAIL done[%0d] t=%0t got %b want %b", i, $time, done[i], m_done[i]);
                end
                total++;
                if (dout[i] !== m_res[i][slice_sel*8 +: 8]) begin
                    bad++;
                    $display("FAIL dout[%0d] t=%0t sel=%0d got %h want %h", i, $time, slice_sel,
                             dout[i], m_res[i][slice_sel*8 +: 8]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
        if (rand_sel) slice_sel = 2'($urandom_range(0, 3));
    endtask

    task automatic shift_in(input logic [15:0] a, input logic [15:0] b);
        for (int k = 15; k >= 0; k--) begin
            sin_a = a[k]; sin_b = b[k]; shift_en = 1'b1;
            cyc();
        end
        shift_en = 1'b0;
    endtask

    task automatic read_result(input int i, output logic [31:0] r);
        rand_sel = 1'b0;
        for (int s = 0; s < 4; s++) begin
            slice_sel = 2'(s);
            #1;
            r[s*8 +: 8] = dout[i];
        end
        rand_sel = 1'b1;
    endtask

    // Loads operands, starts, then waits (bounded) for both instances to finish.
    task automatic do_mul(input logic [15:0] a, input logic [15:0] b, input logic sm,
                          output int busy0, output int dly1, output int dn0);
        shift_in(a, b);
        signed_mode = sm; start = 1'b1;
        cyc();
        start = 1'b0;
        busy0 = 0; dly1 = -1; dn0 = 0;
        for (int c = 1; c <= 40; c++) begin
            if (busy[0]) busy0++;
            cyc();
            if (done[1] && dly1 < 0) dly1 = c;
            if (done[0]) dn0++;
            if (!busy[0] && !busy[1] && dly1 >= 0 && dn0 > 0) break;
        end
    endtask

    task automatic mul_check(input string nm, input logic [15:0] a, input logic [15:0] b,
                             input logic sm, input logic [31:0] exp);
        int b0, d1, n0;
        logic [31:0] r;
        do_mul(a, b, sm, b0, d1, n0);
        chk({nm, "_busy0"}, 64'(b0), 64'd17);
        chk({nm, "_done0_count"}, 64'(n0), 64'd1);
        chk({nm, "_done1_delay"}, 64'(d1), 64'd5);
        read_result(0, r);
        chk({nm, "_res0"}, 64'(r), 64'(exp));
        read_result(1, r);
        chk({nm, "_res1"}, 64'(r), 64'(exp));
    endtask

    initial begin
        logic [31:0] r;
        logic [15:0] a, b;
        logic        sm;

        rst_n = 1'b0; sin_a = 1'b0; sin_b = 1'b0; shift_en = 1'b0;
        start = 1'b0; signed_mode = 1'b0; slice_sel = '0;
        cyc();
        chk_on = 1'b1;
        rst_n = 1'b1;
        chk("rst_busy0", 64'(busy[0]), 64'd0);
        chk("rst_done0", 64'(done[0]), 64'd0);
        chk("rst_dout0", 64'(dout[0]), 64'd0);
        chk("rst_dout1", 64'(dout[1]), 64'd0);

        // Directed products; model pinned against literals too.
        mul_check("u3x5", 16'h0003, 16'h0005, 1'b0, 32'h0000000F);
        chk("model_3x5", 64'(m_res[0]), 64'h0000000F);
        mul_check("uFFFFsq", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
        chk("model_uFFFFsq", 64'(m_res[1]), 64'hFFFE0001);
        mul_check("sFFFFsq", 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
        mul_check("sFFFFx2", 16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE);
        mul_check("s8000sq", 16'h8000, 16'h8000, 1'b1, 32'h40000000);
        chk("model_s8000sq", 64'(m_res[0]), 64'h40000000);
        mul_check("s8000x1", 16'h8000, 16'h0001, 1'b1, 32'hFFFF8000);
        mul_check("u1234x5678", 16'h1234, 16'h5678, 1'b0, 32'h06260060);

        // start and shift_en while busy are ignored by the slow instance.
        shift_in(16'h00AB, 16'h0123);
        signed_mode = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (4) cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            shift_en = k[0]; sin_a = 1'($urandom); sin_b = 1'($urandom);
            cyc();
        end
        shift_en = 1'b0;
        for (int c = 0; c < 40 && (busy[0] || busy[1]); c++) cyc();
        chk("busy_ign_idle", 64'(busy[0]), 64'd0);
        read_result(0, r);
        chk("busy_ign_res0", 64'(r), 64'h0000C261);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int c = 0; c < 40 && (busy[0] || busy[1]); c++) cyc();
        read_result(0, r);
        chk("sr_held_res0", 64'(r), 64'h0000C261);

        // Reset mid-RUN abandons the operation.
        shift_in(16'h0003, 16'h0005);
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("midrst_busy0", 64'(busy[0]), 64'd0);
        chk("midrst_busy1", 64'(busy[1]), 64'd0);
        chk("midrst_done0", 64'(done[0]), 64'd0);
        chk("midrst_dout0", 64'(dout[0]), 64'd0);
        repeat (20) cyc();
        mul_check("after_rst", 16'h0007, 16'h0009, 1'b0, 32'h0000003F);

        // Random vectors, both modes, with corner operands mixed in.
        for (int v = 0; v < 1000; v++) begin
            case ($urandom_range(0, 7))
                0: a = 16'h8000;
                1: a = 16'hFFFF;
                2: a = 16'h0000;
                default: a = 16'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0: b = 16'h8000;
                1: b = 16'hFFFF;
                2: b = 16'h0001;
                default: b = 16'($urandom);
            endcase
            sm = 1'($urandom);
            mul_check("rand", a, b, sm, ref_mul(a, b, sm));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
